// File: rtl/booth_mult_datapath.sv
// Radix-4 Booth multiplier datapath and sequencer: 32x32 signed, 16 two-bit steps.
// Define MULT_OVF_EN to register a signed 32-bit overflow flag on completion.
module booth_mult_datapath (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic [2:0]  booth_bits,
    input  logic        aos,
    input  logic        sm,
    input  logic        nop,
    output logic        ctrl_clr,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] result,
    output logic        ovf
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [33:0] acc_q, acc_d;
    logic [31:0] qr_q, qr_d;
    logic [31:0] mr_q, mr_d;
    logic        qm1_q, qm1_d;
    logic [3:0]  step_q, step_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic        ctrl_clr_q, ctrl_clr_d;
    logic [33:0] addend;
    logic [33:0] acc_sum;

    always_comb begin
        addend  = sm ? {mr_q[31], mr_q, 1'b0} : {{2{mr_q[31]}}, mr_q};
        acc_sum = acc_q;
        if (!nop) begin
            acc_sum = aos ? (acc_q - addend) : (acc_q + addend);
        end

        state_d = state_q;
        acc_d   = acc_q;
        qr_d    = qr_q;
        mr_d    = mr_q;
        qm1_d   = qm1_q;
        step_d  = step_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    mr_d    = multiplicand;
                    qr_d    = multiplier;
                    acc_d   = '0;
                    qm1_d   = 1'b0;
                    step_d  = '0;
                    state_d = StLoad;
                end
            end
            StLoad: state_d = StRun;
            StRun: begin
                // Arithmetic shift of {ACC', QR, QM1} by two, sign from ACC'.
                acc_d  = {{2{acc_sum[33]}}, acc_sum[33:2]};
                qr_d   = {acc_sum[1:0], qr_q[31:2]};
                qm1_d  = qr_q[1];
                step_d = step_q + 4'd1;
                if (step_q == 4'd15) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d     = (state_d == StLoad) || (state_d == StRun);
        valid_d    = (state_d == StDone);
        ctrl_clr_d = (state_d == StLoad);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            qr_q       <= '0;
            mr_q       <= '0;
            qm1_q      <= 1'b0;
            step_q     <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            ctrl_clr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            qr_q       <= qr_d;
            mr_q       <= mr_d;
            qm1_q      <= qm1_d;
            step_q     <= step_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            ctrl_clr_q <= ctrl_clr_d;
        end
    end

    assign booth_bits   = {qr_q[1], qr_q[0], qm1_q};
    assign ctrl_clr     = ctrl_clr_q;
    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign result       = qr_q;

`ifdef MULT_OVF_EN
    logic        ovf_q, ovf_d;
    logic [32:0] prod_hi;

    always_comb begin
        // Product bits [63:31]; all equal means the product fits in 32 signed bits.
        prod_hi = {acc_d[31:0], qr_d[31]};
        ovf_d   = ovf_q;
        if (state_d == StLoad) begin
            ovf_d = 1'b0;
        end else if ((state_q == StRun) && (state_d == StDone)) begin
            ovf_d = !((&prod_hi) || (~|prod_hi));
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule
